bus_xfer_sequencer: RTL and testbench

//  Sequences register-to-register transfers on the shared 8-bit tristate bus.

---
 rtl/bus_xfer_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// Sequences queued MOV commands onto the shared 8-bit tristate bus, owning every
// per-register outflag/inflag strobe so exactly one source drives before a load.
module bus_xfer_sequencer #(
    parameter int NREG  = 8,
    parameter int IDXW  = 3,
    parameter int DEPTH = 4,
    parameter int SETUP = 1
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_ext,
    input  logic [IDXW-1:0] cmd_src,
    input  logic [IDXW-1:0] cmd_dst,
    output logic [NREG-1:0] outflag,
    output logic [NREG-1:0] inflag,
    output logic            ext_oe,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int              PTRW    = $clog2(DEPTH);
    localparam int              CW      = 2 * IDXW + 1;
    localparam logic [IDXW:0]   NREG_L  = (IDXW + 1)'(NREG);
    localparam logic [3:0]      SETUP_L = 4'(SETUP);
    localparam logic [PTRW:0]   DEPTH_L = (PTRW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LOAD, S_HOLD} state_t;

    logic [CW-1:0]   fifo_mem [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]   count_q, count_d;

    logic            stg_valid_q, stg_valid_d;
    logic            stg_ext_q, stg_ext_d;
    logic [IDXW-1:0] stg_src_q, stg_src_d;
    logic [IDXW-1:0] stg_dst_q, stg_dst_d;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] dst_q, dst_d;
    logic [NREG-1:0] outflag_q, outflag_d;
    logic [NREG-1:0] inflag_q, inflag_d;
    logic            ext_oe_q, ext_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            push, pop, consume, cmd_bad;
    logic [CW-1:0]   head;

    assign cmd_ready = (count_q != DEPTH_L);
    assign push      = cmd_valid & cmd_ready;
    // The staging register is the FIFO's output slot; the FSM only takes from it in IDLE.
    assign consume   = (state_q == S_IDLE) & stg_valid_q;
    assign pop       = (count_q != '0) & (~stg_valid_q | consume);
    assign head      = fifo_mem[rd_ptr_q];
    assign cmd_bad   = (~stg_ext_q & ({1'b0, stg_src_q} >= NREG_L))
                     | ({1'b0, stg_dst_q} >= NREG_L)
                     | (~stg_ext_q & (stg_src_q == stg_dst_q));

    assign outflag = outflag_q;
    assign inflag  = inflag_q;
    assign ext_oe  = ext_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_ext, cmd_src, cmd_dst};
        end
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTRW + 1)'(1);
            2'b01:   count_d = count_q - (PTRW + 1)'(1);
            default: count_d = count_q;
        endcase

        stg_valid_d = stg_valid_q;
        stg_ext_d   = stg_ext_q;
        stg_src_d   = stg_src_q;
        stg_dst_d   = stg_dst_q;
        if (pop) begin
            {stg_ext_d, stg_src_d, stg_dst_d} = head;
            stg_valid_d = 1'b1;
        end else if (consume) begin
            stg_valid_d = 1'b0;
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_d     = dst_q;
        outflag_d = outflag_q;
        inflag_d  = inflag_q;
        ext_oe_d  = ext_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (consume) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                        cnt_d   = 4'd1;
                        dst_d   = stg_dst_q;
                        if (stg_ext_q) begin
                            ext_oe_d = 1'b1;
                        end else begin
                            outflag_d = NREG'(1) << stg_src_q;
                        end
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == SETUP_L) begin
                    state_d  = S_LOAD;
                    inflag_d = NREG'(1) << dst_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_LOAD: begin
                state_d  = S_HOLD;
                inflag_d = '0;
                done_d   = 1'b1;
            end
            S_HOLD: begin
                state_d   = S_IDLE;
                outflag_d = '0;
                ext_oe_d  = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                outflag_d = '0;
                inflag_d  = '0;
                ext_oe_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) | (count_d != '0) | stg_valid_d;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stg_valid_q <= 1'b0;
            stg_ext_q   <= 1'b0;
            stg_src_q   <= '0;
            stg_dst_q   <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dst_q       <= '0;
            outflag_q   <= '0;
            inflag_q    <= '0;
            ext_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stg_valid_q <= stg_valid_d;
            stg_ext_q   <= stg_ext_d;
            stg_src_q   <= stg_src_d;
            stg_dst_q   <= stg_dst_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            outflag_q   <= outflag_d;
            inflag_q    <= inflag_d;
            ext_oe_q    <= ext_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: directed scenarios plus a random command stream,
// checked cycle by cycle against a schedule-based reference model.
module tb_bus_xfer_sequencer;
    localparam int NREG  = 8;
    localparam int IDXW  = 4;
    localparam int DEPTH = 4;
    localparam int SETUP = 2;
    localparam int MAXC  = 32768;

    logic            clk = 1'b0;
    logic            RESET = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ext = 1'b0;
    logic [IDXW-1:0] cmd_src = '0;
    logic [IDXW-1:0] cmd_dst = '0;
    logic            cmd_ready;
    logic [NREG-1:0] outflag;
    logic [NREG-1:0] inflag;
    logic            ext_oe;
    logic            busy;
    logic            done;
    logic            err;

    bus_xfer_sequencer #(.NREG(NREG), .IDXW(IDXW), .DEPTH(DEPTH), .SETUP(SETUP)) dut (
        .clk(clk), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ext(cmd_ext), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .outflag(outflag), .inflag(inflag), .ext_oe(ext_oe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs, filled in whenever a command is accepted.
    logic [NREG-1:0] e_out [MAXC];
    logic [NREG-1:0] e_in  [MAXC];
    bit              e_ext [MAXC];
    bit              e_done[MAXC];
    bit              e_err [MAXC];
    int              e_busy[MAXC];
    int              e_fifo[MAXC];

    int cyc, free_t, prev_start;
    int n_checks = 0;
    int n_fail = 0;
    int seg_acc, seg_done, seg_err, ext_hi;
    bit strobe_seen;
    logic [NREG-1:0] in_or, out_or;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < MAXC; k++) begin
            e_out[k] = '0; e_in[k] = '0; e_ext[k] = 0; e_done[k] = 0;
            e_err[k] = 0; e_busy[k] = 0; e_fifo[k] = 0;
        end
        cyc = 0; free_t = -100; prev_start = -100;
        seg_acc = 0; seg_done = 0; seg_err = 0;
    endtask

    // A command accepted at edge t waits in the queue until it can be staged,
    // starts at max(t+2, when the previous transfer frees the bus), and occupies
    // SETUP+3 cycles if valid or a single err cycle if rejected.
    task automatic model_accept(input bit ext, input int src, input int dst);
        int t, p, s, e;
        bit bad;
        t = cyc + 1;
        p = imax(t + 1, prev_start);
        s = imax(t + 2, free_t);
        bad = (!ext && src >= NREG) || (dst >= NREG) || (!ext && src == dst);
        for (int k = t; k < p; k++) e_fifo[k]++;
        if (bad) begin
            e_err[s] = 1;
            e = s;
            free_t = s + 1;
        end else begin
            for (int k = s; k <= s + SETUP + 1; k++) begin
                if (ext) e_ext[k] = 1;
                else     e_out[k][src] = 1'b1;
            end
            e_in[s + SETUP][dst] = 1'b1;
            e_done[s + SETUP + 1] = 1;
            e = s + SETUP + 2;
            free_t = s + SETUP + 3;
        end
        for (int k = t; k < e; k++) e_busy[k]++;
        prev_start = s;
        seg_acc++;
    endtask

    task automatic check_output();
        chk("cmd_ready", 32'(cmd_ready), 32'(e_fifo[cyc] < DEPTH));
        chk("outflag",   32'(outflag),   32'(e_out[cyc]));
        chk("inflag",    32'(inflag),    32'(e_in[cyc]));
        chk("ext_oe",    32'(ext_oe),    32'(e_ext[cyc]));
        chk("busy",      32'(busy),      32'(e_busy[cyc] != 0));
        chk("done",      32'(done),      32'(e_done[cyc]));
        chk("err",       32'(err),       32'(e_err[cyc]));
        chk("inv_outflag_onehot0", 32'($onehot0(outflag)), 32'(1));
        chk("inv_src_exclusive",   32'((|outflag) && ext_oe), 32'(0));
        chk("inv_inflag_onehot0",  32'($onehot0(inflag)), 32'(1));
        chk("inv_inflag_sourced",  32'((|inflag) && !((|outflag) || ext_oe)), 32'(0));
        chk("inv_in_out_disjoint", 32'(|(inflag & outflag)), 32'(0));
        chk("inv_done_err",        32'(done && err), 32'(0));
        if (done === 1'b1) seg_done++;
        if (err === 1'b1) seg_err++;
        if (ext_oe === 1'b1) ext_hi++;
        strobe_seen = strobe_seen | (|outflag) | (|inflag) | ext_oe;
        in_or  = in_or | inflag;
        out_or = out_or | outflag;
    endtask

    task automatic apply_stimulus(input bit v, input bit ext, input int src, input int dst,
                                  output bit acc);
        cmd_valid = v;
        cmd_ext   = ext;
        cmd_src   = IDXW'(src);
        cmd_dst   = IDXW'(dst);
        acc = v && (e_fifo[cyc] < DEPTH);
        if (acc) model_accept(ext, src, dst);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step(input bit v, input bit ext, input int src, input int dst, output bit acc);
        if (cyc >= MAXC - 64) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL cycle_budget: observed cycle %0d required below %0d", cyc, MAXC - 64);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        check_output();
        apply_stimulus(v, ext, src, dst, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, acc);
    endtask

    task automatic send(input bit ext, input int src, input int dst);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 100) begin
            step(1, ext, src, dst, acc);
            n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        bit acc;
        while (busy !== 1'b0 && n < 400) begin
            step(0, 0, 0, 0, acc);
            n++;
        end
        chk("drain_bound", 32'(n < 400), 32'(1));
        step(0, 0, 0, 0, acc);
    endtask

    task automatic do_reset();
        #2;
        RESET = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rst_outflag",   32'(outflag),   32'(0));
        chk("rst_inflag",    32'(inflag),    32'(0));
        chk("rst_ext_oe",    32'(ext_oe),    32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_done",      32'(done),      32'(0));
        chk("rst_err",       32'(err),       32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;
        model_clear();
    endtask

    initial begin
        int t0, rel, sent, guard, issued, e0, d0;
        bit acc, saw_low, pending, p_ext;
        int p_src, p_dst;

        model_clear();
        @(negedge clk);
        $display("[TB] reset pulse");
        do_reset();
        idle(2);

        $display("[TB] single MOV 2->5");
        send(0, 2, 5);
        t0 = cyc;
        for (int i = 0; i < SETUP + 6; i++) begin
            rel = cyc - t0;
            chk("t2_outflag", 32'(outflag), (rel >= 2 && rel <= SETUP + 3) ? 32'h04 : 32'h00);
            chk("t2_inflag",  32'(inflag),  (rel == SETUP + 2) ? 32'h20 : 32'h00);
            chk("t2_done",    32'(done),    32'(rel == SETUP + 3));
            step(0, 0, 0, 0, acc);
        end

        $display("[TB] back-to-back burst");
        sent = 0; guard = 0; saw_low = 0; d0 = seg_done;
        while (sent < 7 && guard < 200) begin
            if (cmd_ready === 1'b0) saw_low = 1;
            step(1, 0, sent, (sent + 1) % NREG, acc);
            if (acc) sent++;
            guard++;
        end
        chk("t3_all_accepted", 32'(sent), 32'(7));
        chk("t3_ready_dropped", 32'(saw_low), 32'(1));
        cmd_valid = 1'b0;
        drain();
        chk("t3_done_count", 32'(seg_done - d0), 32'(7));

        $display("[TB] rejected commands");
        e0 = seg_err; d0 = seg_done; strobe_seen = 0;
        send(0, 3, 3);
        send(0, 2, 9);
        drain();
        chk("t4_err_count", 32'(seg_err - e0), 32'(2));
        chk("t4_no_strobe", 32'(strobe_seen), 32'(0));
        send(0, 1, 6);
        drain();
        chk("t4_followup_done", 32'(seg_done - d0), 32'(1));

        $display("[TB] external source");
        ext_hi = 0; in_or = '0; out_or = '0;
        send(1, 7, 0);
        drain();
        chk("t5_ext_cycles", 32'(ext_hi), 32'(SETUP + 2));
        chk("t5_inflag", 32'(in_or), 32'h01);
        chk("t5_outflag_zero", 32'(out_or), 32'h00);

        $display("[TB] reset mid-transfer");
        send(0, 4, 1);
        idle(3);
        do_reset();
        idle(SETUP + 6);
        chk("rst_no_done", 32'(seg_done), 32'(0));

        $display("[TB] random stream");
        issued = 0; guard = 0; pending = 0;
        p_ext = 0; p_src = 0; p_dst = 0;
        while (issued < 2000 && guard < 20000) begin
            if (!pending && $urandom_range(0, 99) < 45) begin
                pending = 1;
                p_ext = ($urandom_range(0, 5) == 0);
                p_src = int'($urandom_range(0, 9));
                p_dst = int'($urandom_range(0, 9));
            end
            step(pending, p_ext, p_src, p_dst, acc);
            if (acc) begin
                pending = 0;
                issued++;
                if (issued == 1000) do_reset();
            end
            guard++;
        end
        cmd_valid = 1'b0;
        drain();
        chk("t6_issued", 32'(issued), 32'(2000));
        chk("t6_done_plus_err", 32'(seg_done + seg_err), 32'(seg_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
